spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
SPI slave endpoint on the other end of the team's 16-bit SPI master link. It oversamples spi_CS, spi_sclk and spiData in the local clk domain and deserialises MSB-first frames. Each completed word is presented on dataOut with a one-cycle dataValid strobe. The block also shifts a local reply word out on spi_miso for full-duplex use.

Parameters:
DATA_WIDTH, 16, bits per frame; also the width of dataOut and txData.
SYNC_STAGES, 2, flip-flop synchroniser depth on spi_CS, spi_sclk and spiData; legal values are 2 and 3.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset (low = reset asserted).
spi_CS  input  1  chip select from the master, active low.
spi_sclk  input  1  SPI clock from the master, idle low (mode 0).
spiData  input  1  MOSI serial data from the master.
txData  input  DATA_WIDTH  reply word; captured at frame start.
spi_miso  output  1  MISO serial data to the master.
dataOut  output  DATA_WIDTH  last complete received word.
dataValid  output  1  one-cycle strobe: dataOut updated.
frameErr  output  1  one-cycle strobe: CS deasserted mid-word.
busy  output  1  high while a frame is active (state SHIFT).
bitCount  output  5  bits received in the current word, 0..DATA_WIDTH-1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift regs=0, dataOut=0, dataValid=0, frameErr=0, busy=0, bitCount=0, spi_miso=0. Synchroniser flops reset to CS=1, sclk=0, data=0.
- Synchronisation: the three SPI inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with a one-cycle-delayed copy. Only the synchronised signals are used after this point.
- Timing requirement: spi_sclk high and low phases are each >= SYNC_STAGES+1 clk periods. spi_CS setup to the first sclk rise is >= SYNC_STAGES+1 clk periods. Faster input is out of scope.
- FSM states: IDLE, SHIFT.
  - IDLE: busy=0, spi_miso=0. On a CS falling edge: load txShift=txData, drive spi_miso=txData[DATA_WIDTH-1], set bitCount=0, go to SHIFT.
  - SHIFT, sclk rising edge detected in cycle k: at the posedge ending cycle k, rxShift={rxShift[DATA_WIDTH-2:0], syncData} and bitCount increments.
  - SHIFT, last bit (the rising edge with bitCount=DATA_WIDTH-1): dataOut={rxShift[DATA_WIDTH-2:0], syncData}, dataValid=1 in cycle k+1 only, bitCount wraps to 0, txShift reloads from txData. The FSM stays in SHIFT, so a continuous stream without a CS toggle yields consecutive words.
  - SHIFT, sclk falling edge: txShift shifts left by one and spi_miso takes the new MSB. No shift occurs on the falling edge that follows the last bit of a word, because the reload already presents the new MSB.
  - SHIFT, CS rising edge: return to IDLE. If bitCount != 0, frameErr=1 for one cycle, the partial word is discarded and dataOut is unchanged. If bitCount == 0, no error is flagged.
- Simultaneous events:
  - A CS rise in the same cycle as an sclk rise: the CS rise wins, the bit is not captured, and frameErr follows the bitCount rule above.
  - dataValid and frameErr are never high in the same cycle.
- sclk edges while CS is high are ignored.
- Reset asserted mid-frame clears everything immediately. The first frame after reset release requires a fresh CS falling edge.
- bitCount is 5 bits wide; with DATA_WIDTH=16 it never exceeds 15.

Test Plan:
1. Reset low for 3 cycles, then release with CS=1 -> all outputs 0, busy=0. Drive sclk toggles while CS=1 -> no dataValid, bitCount stays 0.
2. Master model (sclk half-period 4 clk) sends 0xA5C3 with txData=0x3C5A -> exactly one dataValid pulse, dataOut=0xA5C3, and the 16 bits sampled on spi_miso equal 0x3C5A MSB-first.
3. Two words 0x1234 and 0xFFFF under one CS low, txData=0x00FF held -> two dataValid pulses with dataOut=0x1234, then 0xFFFF. MISO carries 0x00FF twice.
4. CS raised after 7 bits of 0xBEEF -> one frameErr pulse, no dataValid, dataOut keeps its previous value, bitCount=0, busy=0. A following full frame 0x0001 is received correctly.
5. reset pulsed low after 9 bits -> outputs cleared at once. A new frame 0x8000 received after CS re-falls -> dataOut=0x8000.
6. CS rise coincident with the 16th sclk rise -> frameErr=1 once, dataValid never asserted, dataOut unchanged.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave_rx_if : SPI pins and parallel word interface of spi_slave_rx
// Rev 1.0
// ----------------------------------------------------------------------------
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  spi_CS;
  logic                  spi_sclk;
  logic                  spiData;
  logic [DATA_WIDTH-1:0] txData;
  logic                  spi_miso;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  dataValid;
  logic                  frameErr;
  logic                  busy;
  logic [4:0]            bitCount;

  modport slave (
    input  spi_CS, spi_sclk, spiData, txData,
    output spi_miso, dataOut, dataValid, frameErr, busy, bitCount
  );

  modport master (
    output spi_CS, spi_sclk, spiData, txData,
    input  spi_miso, dataOut, dataValid, frameErr, busy, bitCount
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave_rx : oversampling mode-0 SPI slave, MSB-first, full duplex
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  spi_slave_rx_if.slave   bus
);
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state_q;
  logic [SYNC_STAGES-1:0]  cs_sync_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q;
  logic [SYNC_STAGES-1:0]  data_sync_q;
  logic                    cs_prev_q;
  logic                    sclk_prev_q;
  logic [DATA_WIDTH-2:0]   rxShift_q;
  logic [DATA_WIDTH-1:0]   txShift_q;
  logic [DATA_WIDTH-1:0]   dataOut_q;
  logic                    dataValid_q;
  logic                    frameErr_q;
  logic                    busy_q;
  logic                    miso_q;
  logic                    reload_q;
  logic [4:0]              bitCount_q;
  logic [4:0]              bitCount_d;

  logic cs_s, sclk_s, data_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall, last_bit;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign last_bit  = (bitCount_q == 5'(DATA_WIDTH-1));
  assign bitCount_d = bitCount_q + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      data_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.spiData};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rxShift_q   <= '0;
      txShift_q   <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      reload_q    <= 1'b0;
      bitCount_q  <= '0;
    end else begin
      dataValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
            txShift_q  <= bus.txData;
            miso_q     <= bus.txData[DATA_WIDTH-1];
            bitCount_q <= '0;
            reload_q   <= 1'b0;
          end
        end
        SHIFT: begin
          // CS release has priority over a coincident sclk rise.
          if (cs_rise) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            miso_q     <= 1'b0;
            frameErr_q <= (bitCount_q != 5'd0);
            bitCount_q <= '0;
            reload_q   <= 1'b0;
          end else if (sclk_rise) begin
            rxShift_q <= {rxShift_q[DATA_WIDTH-3:0], data_s};
            if (last_bit) begin
              dataOut_q   <= {rxShift_q, data_s};
              dataValid_q <= 1'b1;
              bitCount_q  <= '0;
              txShift_q   <= bus.txData;
              miso_q      <= bus.txData[DATA_WIDTH-1];
              reload_q    <= 1'b1;
            end else begin
              bitCount_q <= bitCount_d;
            end
          end else if (sclk_fall) begin
            // The reload already put the next word's MSB on MISO.
            if (reload_q) begin
              reload_q <= 1'b0;
            end else begin
              txShift_q <= txShift_q << 1;
              miso_q    <= txShift_q[DATA_WIDTH-2];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.dataOut   = dataOut_q;
  assign bus.dataValid = dataValid_q;
  assign bus.frameErr  = frameErr_q;
  assign bus.busy      = busy_q;
  assign bus.bitCount  = bitCount_q;
endmodule
`default_nettype wire
